// File: rtl/ysyx_25040129_lsu.sv
// Load/store unit: takes one EXU result, performs at most one bus access, returns the result to the WBU.
// Optional misaligned-access trap: define YSYX_25040129_LSU_MISALIGN_EN.
module ysyx_25040129_lsu #(
    parameter int REGS_DIG = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_req_valid_from_exu,
    output logic                is_req_ready_to_exu,
    input  logic [31:0]         addr_in_lsu,
    input  logic [31:0]         lsu_write_data_in_lsu,
    input  logic [2:0]          lsu_read_in_lsu,
    input  logic [1:0]          lsu_write_in_lsu,
    input  logic [REGS_DIG-1:0] rd_in_lsu,
    input  logic                reg_write_in_lsu,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_addr,
    output logic                mem_wen,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_resp_err,
    output logic                is_wb_valid_to_wbu,
    input  logic                is_wb_ready_from_wbu,
    output logic [31:0]         result_out_lsu,
    output logic [REGS_DIG-1:0] rd_out_lsu,
    output logic                reg_write_out_lsu,
    output logic                bus_err_out_lsu
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, OUT} state_t;

    localparam logic [2:0] LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3, LD_LBU = 3'd4, LD_LHU = 3'd5;
    localparam logic [1:0] ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;

    state_t              state_reg, state_next;
    logic [31:0]         addr_reg, wd_reg, result_reg;
    logic [2:0]          ld_reg;
    logic [1:0]          st_reg;
    logic [REGS_DIG-1:0] rd_reg;
    logic                rw_reg, err_reg;
    logic                accept;

    // Incoming request decode; a store overrides any load code, unknown load codes mean no load.
    logic [2:0] ld_in;
    logic       mem_op_in, misalign_in;

    always_comb begin
        ld_in = 3'd0;
        if (lsu_write_in_lsu == 2'd0 && lsu_read_in_lsu >= LD_LB && lsu_read_in_lsu <= LD_LHU)
            ld_in = lsu_read_in_lsu;
    end

    assign mem_op_in = (lsu_write_in_lsu != 2'd0) || (ld_in != 3'd0);

`ifdef YSYX_25040129_LSU_MISALIGN_EN
    assign misalign_in = ((ld_in == LD_LH || ld_in == LD_LHU || lsu_write_in_lsu == ST_SH) && addr_in_lsu[0])
                      || ((ld_in == LD_LW || lsu_write_in_lsu == ST_SW) && (addr_in_lsu[1:0] != 2'b00));
`else
    assign misalign_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next          = state_reg;
        accept              = 1'b0;
        is_req_ready_to_exu = 1'b0;
        mem_req_valid       = 1'b0;
        is_wb_valid_to_wbu  = 1'b0;
        case (state_reg)
            IDLE: begin
                is_req_ready_to_exu = 1'b1;
                if (is_req_valid_from_exu) begin
                    accept     = 1'b1;
                    state_next = (mem_op_in && !misalign_in) ? ISSUE : OUT;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (mem_resp_valid) state_next = OUT;
            end
            OUT: begin
                is_wb_valid_to_wbu = 1'b1;
                if (is_wb_ready_from_wbu) begin
                    is_req_ready_to_exu = 1'b1;
                    state_next          = IDLE;
                    if (is_req_valid_from_exu) begin
                        accept     = 1'b1;
                        state_next = (mem_op_in && !misalign_in) ? ISSUE : OUT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Load alignment: shift the addressed byte/half down to bit 0, then extend.
    logic [15:0] sh;
    logic [31:0] load_data;
    assign sh = 16'(mem_rdata >> {addr_reg[1:0], 3'b000});

    always_comb begin
        case (ld_reg)
            LD_LB:   load_data = {{24{sh[7]}}, sh[7:0]};
            LD_LH:   load_data = {{16{sh[15]}}, sh[15:0]};
            LD_LW:   load_data = mem_rdata;
            LD_LBU:  load_data = {24'd0, sh[7:0]};
            LD_LHU:  load_data = {16'd0, sh[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg   <= 32'd0;
            wd_reg     <= 32'd0;
            result_reg <= 32'd0;
            ld_reg     <= 3'd0;
            st_reg     <= 2'd0;
            rd_reg     <= '0;
            rw_reg     <= 1'b0;
            err_reg    <= 1'b0;
        end else if (accept) begin
            addr_reg   <= addr_in_lsu;
            wd_reg     <= lsu_write_data_in_lsu;
            ld_reg     <= ld_in;
            st_reg     <= lsu_write_in_lsu;
            rd_reg     <= rd_in_lsu;
            rw_reg     <= reg_write_in_lsu && !misalign_in;
            err_reg    <= misalign_in;
            result_reg <= mem_op_in ? 32'd0 : addr_in_lsu;
        end else if (state_reg == WAIT_RESP && mem_resp_valid) begin
            err_reg    <= mem_resp_err;
            result_reg <= mem_resp_err ? 32'd0 : load_data;
            if (mem_resp_err) rw_reg <= 1'b0;
        end
    end

    // Store lanes: every byte lane carries the data it would hold for any legal offset.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign mem_wdata[8*gi +: 8] = (st_reg == ST_SB) ? wd_reg[7:0] :
                                      (st_reg == ST_SH) ? wd_reg[8*(gi%2) +: 8] :
                                      (st_reg == ST_SW) ? wd_reg[8*gi +: 8] : 8'd0;
    end

    always_comb begin
        case (st_reg)
            ST_SB:   mem_wstrb = 4'b0001 << addr_reg[1:0];
            ST_SH:   mem_wstrb = addr_reg[1] ? 4'b1100 : 4'b0011;
            ST_SW:   mem_wstrb = 4'b1111;
            default: mem_wstrb = 4'b0000;
        endcase
    end

    assign mem_addr          = addr_reg;
    assign mem_wen           = (st_reg != 2'd0);
    assign result_out_lsu    = result_reg;
    assign rd_out_lsu        = rd_reg;
    assign reg_write_out_lsu = rw_reg;
    assign bus_err_out_lsu   = err_reg;

endmodule
